// File: rtl/phase_sweep_sequencer_if.sv
// Sweep-sequencer bus: sweep configuration, control pulses, stepper handshake and settled-point status.
// The master modport is the sequencer; the slave modport is the controller/stepper side.
interface phase_sweep_sequencer_if #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 16
);
    logic signed [PHASE_WIDTH-1:0] cfg_start;
    logic signed [PHASE_WIDTH-1:0] cfg_stop;
    logic        [PHASE_WIDTH-1:0] cfg_step;
    logic        [DWELL_WIDTH-1:0] cfg_dwell;
    logic                          cfg_loop;
    logic                          start;
    logic                          abort;
    logic signed [PHASE_WIDTH-1:0] target;
    logic                          configure;
    logic                          configured;
    logic                          busy;
    logic                          point_valid;
    logic signed [PHASE_WIDTH-1:0] point_phase;
    logic                          done;
    logic                          aborted;
    logic                          error;

    modport master (
        input  cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_loop, start, abort, configured,
        output target, configure, busy, point_valid, point_phase, done, aborted, error
    );

    modport slave (
        output cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_loop, start, abort, configured,
        input  target, configure, busy, point_valid, point_phase, done, aborted, error
    );
endinterface

// File: rtl/phase_sweep_sequencer.sv
// Steps the MMCM phase-shift stage through a sweep of absolute phase targets, dwelling at each
// point and flagging it settled for downstream trigger logic.
module phase_sweep_sequencer #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    phase_sweep_sequencer_if.master sif
);
    // Two guard bits: cur (signed) plus a full-range unsigned step can exceed PHASE_WIDTH+1 bits.
    localparam int XW = PHASE_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DWELL, ADVANCE} state_t;

    state_t                        state;
    logic signed [PHASE_WIDTH-1:0] start_q, stop_q, cur;
    logic        [PHASE_WIDTH-1:0] step_q;
    logic        [DWELL_WIDTH-1:0] dwell_q, cnt;
    logic                          loop_q, dir_up, abort_q;

    logic signed [XW-1:0]          cur_x, step_x, stop_x, sum_x;
    logic signed [PHASE_WIDTH-1:0] next_pt;
    logic                          abort_pend, at_stop;

    always_comb begin
        cur_x   = XW'(cur);
        stop_x  = XW'(stop_q);
        step_x  = {2'b00, step_q};
        sum_x   = dir_up ? (cur_x + step_x) : (cur_x - step_x);
        next_pt = sum_x[PHASE_WIDTH-1:0];
        // Clamping on overshoot of stop also catches signed overflow, since stop is in range.
        if (dir_up ? (sum_x > stop_x) : (sum_x < stop_x))
            next_pt = stop_q;
        abort_pend = abort_q | sif.abort;
        at_stop    = (cur == stop_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            start_q         <= '0;
            stop_q          <= '0;
            step_q          <= '0;
            dwell_q         <= '0;
            loop_q          <= 1'b0;
            dir_up          <= 1'b1;
            cur             <= '0;
            cnt             <= '0;
            abort_q         <= 1'b0;
            sif.target      <= '0;
            sif.configure   <= 1'b0;
            sif.busy        <= 1'b0;
            sif.point_valid <= 1'b0;
            sif.point_phase <= '0;
            sif.done        <= 1'b0;
            sif.aborted     <= 1'b0;
            sif.error       <= 1'b0;
        end else begin
            sif.configure   <= 1'b0;
            sif.point_valid <= 1'b0;
            sif.done        <= 1'b0;
            sif.aborted     <= 1'b0;
            if (state != IDLE && sif.abort)
                abort_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (sif.start) begin
                        start_q <= sif.cfg_start;
                        stop_q  <= sif.cfg_stop;
                        step_q  <= sif.cfg_step;
                        dwell_q <= sif.cfg_dwell;
                        loop_q  <= sif.cfg_loop;
                        abort_q <= 1'b0;
                        if (sif.cfg_step == '0) begin
                            sif.error <= 1'b1;
                        end else begin
                            sif.error     <= 1'b0;
                            cur           <= sif.cfg_start;
                            dir_up        <= (sif.cfg_stop >= sif.cfg_start);
                            sif.target    <= sif.cfg_start;
                            sif.configure <= 1'b1;
                            sif.busy      <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT_BUSY;
                // Only a fresh low on configured proves the stepper took this request.
                WAIT_BUSY: if (!sif.configured) state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (sif.configured) begin
                        state <= DWELL;
                        cnt   <= dwell_q;
                        if (abort_pend) begin
                            sif.aborted <= 1'b1;
                        end else if (dwell_q == '0) begin
                            sif.point_valid <= 1'b1;
                            sif.point_phase <= cur;
                        end
                    end
                end
                DWELL: begin
                    if (sif.aborted) begin
                        state    <= IDLE;
                        sif.busy <= 1'b0;
                        abort_q  <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= ADVANCE;
                        if (abort_pend) sif.aborted <= 1'b1;
                        else            sif.done    <= at_stop && !loop_q;
                    end else begin
                        cnt <= cnt - DWELL_WIDTH'(1);
                        // Registered pulse lands on the cycle the counter reads zero.
                        if (cnt == DWELL_WIDTH'(1) && !abort_pend) begin
                            sif.point_valid <= 1'b1;
                            sif.point_phase <= cur;
                        end
                    end
                end
                ADVANCE: begin
                    if (sif.aborted) begin
                        state    <= IDLE;
                        sif.busy <= 1'b0;
                        abort_q  <= 1'b0;
                    end else if (at_stop) begin
                        if (loop_q) begin
                            cur           <= start_q;
                            sif.target    <= start_q;
                            sif.configure <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            state    <= IDLE;
                            sif.busy <= 1'b0;
                            abort_q  <= 1'b0;
                        end
                    end else begin
                        cur           <= next_pt;
                        sif.target    <= next_pt;
                        sif.configure <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phase_sweep_sequencer.sv
// Self-checking bench: stepper model plus a point-list reference computed from the sweep rules.
module tb_phase_sweep_sequencer;
    localparam int PW = 32;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_sweep_sequencer_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) sif ();
    phase_sweep_sequencer #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (.clk(clk), .rst(rst), .sif(sif));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stepper model: stale configured=1 on the cycle after accept, then low for 1..4 cycles.
    int sp_state = 0;
    int sp_cnt   = 0;
    always @(posedge clk) begin
        if (rst) begin
            sif.configured <= 1'b1;
            sp_state       <= 0;
        end else begin
            case (sp_state)
                0: if (sif.configure) sp_state <= 1;
                1: begin sif.configured <= 1'b0; sp_cnt <= int'($urandom_range(0, 3)); sp_state <= 2; end
                default: if (sp_cnt == 0) begin sif.configured <= 1'b1; sp_state <= 0; end
                         else sp_cnt <= sp_cnt - 1;
            endcase
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    int cyc = 0;
    always @(posedge clk) cyc++;
    logic signed [63:0] cfg_q[$], pv_q[$], exp_q[$];
    int lat_q[$], gap_q[$];
    int done_n = 0, ab_n = 0, rise_cyc = 0, last_pv = -1;
    logic prev_cfgd = 1'b0;
    always @(negedge clk) begin
        if (sif.configure) begin
            cfg_q.push_back(sif.target);
            if (last_pv >= 0) gap_q.push_back(cyc - last_pv);
        end
        if (sif.configured && !prev_cfgd) rise_cyc = cyc;
        prev_cfgd = sif.configured;
        if (sif.point_valid) begin
            pv_q.push_back(sif.point_phase);
            lat_q.push_back(cyc - rise_cyc);
            last_pv = cyc;
        end
        if (sif.done)    done_n++;
        if (sif.aborted) ab_n++;
    end

    function automatic void build_points(input longint s, input longint e, input longint st);
        longint cur = s;
        longint nxt;
        exp_q.delete();
        while (1) begin
            exp_q.push_back(cur);
            if (cur == e) break;
            nxt = (e >= s) ? cur + st : cur - st;
            if ((e >= s && nxt > e) || (e < s && nxt < e)) nxt = e;
            cur = nxt;
        end
    endfunction

    task automatic clear_mon();
        cfg_q.delete(); pv_q.delete(); lat_q.delete(); gap_q.delete();
        done_n = 0; ab_n = 0; last_pv = -1;
    endtask

    task automatic pulse_start(input logic signed [31:0] s, input logic signed [31:0] e,
                               input logic [31:0] st, input logic [15:0] dw, input logic lp);
        @(posedge clk); #1;
        sif.cfg_start = s; sif.cfg_stop = e; sif.cfg_step = st; sif.cfg_dwell = dw; sif.cfg_loop = lp;
        sif.start = 1'b1;
        @(posedge clk); #1;
        sif.start = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input logic signed [31:0] s, input logic signed [31:0] e,
                             input logic [31:0] st, input logic [15:0] dw, input bit noisy);
        int k = 0;
        int n;
        build_points(s, e, st);
        clear_mon();
        pulse_start(s, e, st, dw, 1'b0);
        chk({tag, "_busy_n1"}, sif.busy, 1);
        chk({tag, "_cfg_n1"}, sif.configure, 1);
        while (done_n == 0 && k < 4000) begin
            @(posedge clk); #1;
            k++;
            sif.start = (noisy && sif.busy && $urandom_range(0, 3) == 0);
        end
        sif.start = 1'b0;
        chk({tag, "_no_timeout"}, (k < 4000), 1);
        chk({tag, "_busy_off"}, sif.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        n = exp_q.size();
        chk({tag, "_n_cfg"}, cfg_q.size(), n);
        chk({tag, "_n_pv"}, pv_q.size(), n);
        for (int i = 0; i < n && i < cfg_q.size(); i++) chk({tag, "_target"}, cfg_q[i], exp_q[i]);
        for (int i = 0; i < n && i < pv_q.size(); i++)  chk({tag, "_phase"}, pv_q[i], exp_q[i]);
        foreach (lat_q[i]) chk({tag, "_pv_latency"}, lat_q[i], int'(dw) + 1);
        chk({tag, "_n_gap"}, gap_q.size(), n - 1);
        foreach (gap_q[i]) chk({tag, "_pv_to_cfg"}, gap_q[i], 2);
        chk({tag, "_done_n"}, done_n, 1);
        chk({tag, "_aborted_n"}, ab_n, 0);
        chk({tag, "_point_phase_held"}, sif.point_phase, e);
        chk({tag, "_busy_idle"}, sif.busy, 0);
        chk({tag, "_error"}, sif.error, 0);
    endtask

    initial begin
        int k;
        sif.cfg_start = '0; sif.cfg_stop = '0; sif.cfg_step = '0; sif.cfg_dwell = '0;
        sif.cfg_loop = 1'b0; sif.start = 1'b0; sif.abort = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", sif.busy, 0);
        chk("rst_target", sif.target, 0);
        chk("rst_point_phase", sif.point_phase, 0);
        chk("rst_configure", sif.configure, 0);
        chk("rst_point_valid", sif.point_valid, 0);
        chk("rst_done", sif.done, 0);
        chk("rst_aborted", sif.aborted, 0);
        chk("rst_error", sif.error, 0);
        rst = 1'b0;

        // Abort in IDLE is ignored.
        sif.abort = 1'b1;
        @(posedge clk); #1;
        sif.abort = 1'b0;
        @(posedge clk); #1;
        chk("idle_abort_aborted", sif.aborted, 0);
        chk("idle_abort_busy", sif.busy, 0);

        run_sweep("up", 0, 10, 4, 3, 1'b0);
        run_sweep("down", 5, -7, 5, 1, 1'b0);

        // Zero step: error set, no sweep; next valid start (single point) clears it.
        clear_mon();
        pulse_start(0, 8, 0, 2, 1'b0);
        chk("step0_error", sif.error, 1);
        chk("step0_busy", sif.busy, 0);
        chk("step0_configure", sif.configure, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("step0_busy_later", sif.busy, 0);
        chk("step0_error_sticky", sif.error, 1);
        chk("step0_no_cfg", cfg_q.size(), 0);
        run_sweep("single", 3, 3, 2, 0, 1'b0);

        run_sweep("ovf", 32'sh7FFFFFF0, 32'sh7FFFFFFF, 32'h20, 2, 1'b1);

        // Loop sweep aborted while the second point's move is in flight.
        clear_mon();
        pulse_start(0, 2, 1, 2, 1'b1);
        k = 0;
        while (!(cfg_q.size() == 2 && sif.configured === 1'b0) && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("abort_reach_point2", (k < 200), 1);
        sif.abort = 1'b1;
        @(posedge clk); #1;
        sif.abort = 1'b0;
        k = 0;
        while (ab_n == 0 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("abort_no_timeout", (k < 200), 1);
        chk("abort_busy_low", sif.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_aborted_n", ab_n, 1);
        chk("abort_n_pv", pv_q.size(), 1);
        if (pv_q.size() > 0) chk("abort_pv0", pv_q[0], 0);
        chk("abort_done_n", done_n, 0);
        chk("abort_n_cfg", cfg_q.size(), 2);
        chk("abort_handshake_done", sif.configured, 1);

        // Randomized sweeps against the reference point list.
        for (int r = 0; r < 6; r++) begin
            logic signed [31:0] s, e;
            s = 32'(int'($urandom_range(0, 40)) - 20);
            e = 32'(int'($urandom_range(0, 40)) - 20);
            run_sweep("rand", s, e, 32'($urandom_range(1, 9)), 16'($urandom_range(0, 4)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
